// File: rtl/cordic_rotation_iter.sv
// Iterative CORDIC rotation-mode engine: one micro-rotation per clock on X/Y/Z,
// with a W+1-bit add/sub per operand feeding a sticky signed-overflow flag.
module cordic_rotation_iter #(
    parameter int W      = 32,
    parameter int N_ITER = 16,
    parameter int CW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beg,
    input  logic [W-1:0]  Data_X_in,
    input  logic [W-1:0]  Data_Y_in,
    input  logic [W-1:0]  Data_Z_in,
    input  logic [W-1:0]  atan_val,
    output logic [CW-1:0] iter_idx,
    output logic [W-1:0]  X_out,
    output logic [W-1:0]  Y_out,
    output logic [W-1:0]  Z_out,
    output logic          busy,
    output logic          ready,
    output logic          ovf
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t state;

    logic signed [W-1:0] sh_x, sh_y;
    logic [W:0] x_ext, y_ext, z_ext, sx_ext, sy_ext, a_ext;
    logic [W:0] x_nxt, y_nxt, z_nxt;
    logic       dir, step_ovf, last;

    // Shift amounts of W or more fill with the sign bit, as arithmetic shifts do.
    always_comb begin
        sh_x     = $signed(X_out) >>> iter_idx;
        sh_y     = $signed(Y_out) >>> iter_idx;
        x_ext    = {X_out[W-1], X_out};
        y_ext    = {Y_out[W-1], Y_out};
        z_ext    = {Z_out[W-1], Z_out};
        sx_ext   = {sh_x[W-1], sh_x};
        sy_ext   = {sh_y[W-1], sh_y};
        a_ext    = {atan_val[W-1], atan_val};
        dir      = Z_out[W-1];
        x_nxt    = dir ? (x_ext + sy_ext) : (x_ext - sy_ext);
        y_nxt    = dir ? (y_ext - sx_ext) : (y_ext + sx_ext);
        z_nxt    = dir ? (z_ext + a_ext)  : (z_ext - a_ext);
        step_ovf = (x_nxt[W] ^ x_nxt[W-1]) | (y_nxt[W] ^ y_nxt[W-1]) |
                   (z_nxt[W] ^ z_nxt[W-1]);
        last     = (iter_idx == CW'(N_ITER - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            X_out    <= '0;
            Y_out    <= '0;
            Z_out    <= '0;
            iter_idx <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (beg) begin
                        X_out    <= Data_X_in;
                        Y_out    <= Data_Y_in;
                        Z_out    <= Data_Z_in;
                        iter_idx <= '0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ITER;
                    end
                end
                ITER: begin
                    X_out <= x_nxt[W-1:0];
                    Y_out <= y_nxt[W-1:0];
                    Z_out <= z_nxt[W-1:0];
                    if (step_ovf) ovf <= 1'b1;
                    if (last) begin
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        state <= DONE;
                    end else begin
                        iter_idx <= iter_idx + 1'b1;
                    end
                end
                DONE: begin
                    ready    <= 1'b0;
                    iter_idx <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cordic_rotation_iter.md
Name: cordic_rotation_iter

Overview:
- Iterative fixed-point CORDIC rotation-mode engine, one micro-rotation per clock.
- Holds the X/Y/Z working registers and generates per-iteration shifted operands and add/sub direction. Each result is computed as a W+1-bit add/sub with carry-out and truncated back to W bits.
- Sits directly upstream of the add/sub datapath in the CORDIC architecture and hands finished X/Y/Z to the FPU interface.
- Arctangent constants come from an external combinational LUT addressed by iter_idx.

Parameters:
- W, 32, data width of X/Y/Z and atan_val; signed two's complement fixed point.
- N_ITER, 16, number of micro-rotations per operation; legal range 1..2^CW-1.
- CW, 5, width of the iteration counter and iter_idx.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- beg  in  1  start request; sampled only in IDLE.
- Data_X_in  in  W  initial X.
- Data_Y_in  in  W  initial Y.
- Data_Z_in  in  W  initial angle Z.
- atan_val  in  W  atan(2^-iter_idx) from the LUT; must be valid in the same cycle as iter_idx.
- iter_idx  out  CW  current iteration index.
- X_out  out  W  X working register.
- Y_out  out  W  Y working register.
- Z_out  out  W  Z working register.
- busy  out  1  high while iterating.
- ready  out  1  one-cycle done pulse.
- ovf  out  1  sticky signed-overflow flag for the current operation.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; X_out, Y_out, Z_out, iter_idx = 0; busy, ready, ovf = 0. Reset mid-operation aborts the operation with no ready pulse.
- State IDLE:
  - beg=1 loads X/Y/Z from the Data_*_in ports, sets iter_idx=0, clears ovf, goes to ITER.
  - beg=0 leaves all registers holding.
- State ITER (busy=1), each cycle with i=iter_idx:
  - d = Z_out[W-1].
  - d=0: X <= X - (Y>>>i); Y <= Y + (X>>>i); Z <= Z - atan_val.
  - d=1: X <= X + (Y>>>i); Y <= Y - (X>>>i); Z <= Z + atan_val.
  - Shifts are arithmetic and use the pre-update register values.
  - Each operation is done on sign-extended W+1-bit operands. If result bits [W] and [W-1] differ, ovf <= 1. The stored value is result[W-1:0] (wrap-around, no saturation).
  - iter_idx increments each cycle. On the cycle with i=N_ITER-1, the update is applied, then the block goes to DONE with iter_idx held at N_ITER-1.
- State DONE (busy=0, ready=1 for exactly one cycle): outputs hold; next state is IDLE, where iter_idx returns to 0 and X/Y/Z hold the results.
- Latency: beg sampled at edge 0 → N_ITER ITER cycles → ready high during cycle N_ITER+1. Back-to-back operations are possible once the block is in IDLE.
- beg is ignored in ITER and DONE; it has no effect on the registers.
- ovf stays set until the next load or reset.
- Shift amounts i ≥ W give all sign bits (arithmetic shift semantics).

Test Plan (W=16, N_ITER=2, CW=5 unless noted):
- Reset at any point → all outputs 0 and state IDLE. Assert rst=0 while busy → busy=0 immediately, no ready pulse, ovf=0.
- X=0x0100, Y=0, Z=0, atan_val tied to 0, beg pulse → ready during cycle 3; X_out=0x0080, Y_out=0x0180, Z_out=0x0000, ovf=0.
- X=0x0100, Y=0, Z=0xFFFF, atan_val=0 → X_out=0x0080, Y_out=0xFE80, Z_out=0xFFFF, ovf=0.
- N_ITER=1: X=0x7FFF, Y=0x7FFF, Z=0, atan_val=0 → X_out=0x0000, Y_out=0xFFFE, ovf=1. A following load with small operands clears ovf to 0.
- Z=0x0010 with a LUT model returning 0x0008 for i=0 and 0x0004 for i=1 → Z_out=0x0004; iter_idx reads 0 then 1 on successive ITER cycles.
- beg held high continuously → operations run back-to-back, one ready pulse every N_ITER+2 cycles; beg pulses during busy change nothing.
